bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns an unsigned binary value into packed BCD digits. It sits directly upstream of the BCD-to-Excess-3 stage. Each 4-bit digit of its `bcd` output feeds one Excess-3 converter instance. A start/busy/done handshake lets a controller launch one conversion at a time and latch the result.

---
 rtl/bin_to_bcd_seq.sv | 94 +++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per clock.
// Start/busy/done handshake; bcd holds the last completed result.
module bin_to_bcd_seq #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);
    localparam int SW = 4 * D + W;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t          state, state_next;
    logic [SW-1:0]   shift_q;
    logic [SW-1:0]   shift_adj;
    logic [SW-1:0]   shift_next;
    logic [CW-1:0]   count_q;
    logic            last_iter;

    // One double-dabble step: correct every digit >= 5, then shift the whole register.
    always_comb begin
        shift_adj = shift_q;
        for (int i = 0; i < D; i++) begin
            if (shift_q[W + 4*i +: 4] >= 4'd5) begin
                shift_adj[W + 4*i +: 4] = shift_q[W + 4*i +: 4] + 4'd3;
            end
        end
        shift_next = shift_adj << 1;
    end

    assign last_iter = (count_q == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONV);
    end

    // bcd is written only on the final iteration, so partial sums never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            count_q <= '0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= {{(4*D){1'b0}}, bin};
                        count_q <= '0;
                    end
                end
                CONV: begin
                    shift_q <= shift_next;
                    count_q <= count_q + CW'(1);
                    if (last_iter) begin
                        done <= 1'b1;
                        bcd  <= shift_next[SW-1 -: 4*D];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
